// File: rtl/memory_access.sv
// rtl/memory_access.sv - pipeline MEM stage: load/store sequencing over a req/ready data-memory port
// ALU results pass straight through; loads and stores park in ACCESS until memory answers.
module memory_access #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [WORD_SIZE-1:0]  alu_result,
  input  logic [WORD_SIZE-1:0]  store_data,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [4:0]            reg_dest_in,
  input  logic                  write_enable_in,
  output logic                  stall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [WORD_SIZE-1:0]  dmem_wdata,
  output logic [3:0]            dmem_wstrb,
  input  logic                  dmem_ready,
  input  logic [WORD_SIZE-1:0]  dmem_rdata,
  output logic [WORD_SIZE-1:0]  data_result,
  output logic [4:0]            reg_dest_out,
  output logic                  write_enable_out,
  output logic                  access_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state_q;
  logic                    req_q, we_q, err_q, wen_out_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WORD_SIZE-1:0]    wdata_q, result_q;
  logic [3:0]              wstrb_q;
  logic [4:0]              rd_out_q, rd_lat_q;
  logic [2:0]              op_q;
  logic [1:0]              off_q;
  logic                    wen_lat_q, store_lat_q;

  logic                    is_mem, bad_op;
  logic [WORD_SIZE-1:0]    wdata_d, load_d;
  logic [3:0]              wstrb_d;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;

  assign is_mem = is_load | is_store;

  // Illegal widths, store-unsigned encodings, and misaligned H/W all fault without a request.
  always_comb begin
    bad_op = 1'b0;
    case (funct3)
      3'b011, 3'b110, 3'b111: bad_op = 1'b1;
      3'b100:                 bad_op = is_store;
      3'b101:                 bad_op = is_store | alu_result[0];
      3'b001:                 bad_op = alu_result[0];
      3'b010:                 bad_op = alu_result[1] | alu_result[0];
      default:                bad_op = 1'b0;
    endcase
  end

  always_comb begin
    wdata_d = store_data;
    wstrb_d = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        wdata_d = {4{store_data[7:0]}};
        wstrb_d = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        wdata_d = {2{store_data[15:0]}};
        wstrb_d = 4'b0011 << alu_result[1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (off_q)
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      2'd3:    ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (op_q[1:0])
      2'b00:   load_d = {{24{ld_byte[7] & ~op_q[2]}}, ld_byte};
      2'b01:   load_d = {{16{ld_half[15] & ~op_q[2]}}, ld_half};
      default: load_d = dmem_rdata;
    endcase
  end

  assign stall = ~reset & (((state_q == IDLE) & in_valid & is_mem)
                         | ((state_q == ACCESS) & ~dmem_ready));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= 4'b0000;
      result_q    <= '0;
      rd_out_q    <= 5'd0;
      wen_out_q   <= 1'b0;
      err_q       <= 1'b0;
      rd_lat_q    <= 5'd0;
      op_q        <= 3'd0;
      off_q       <= 2'd0;
      wen_lat_q   <= 1'b0;
      store_lat_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (!in_valid) begin
            wen_out_q <= 1'b0;
          end else if (!is_mem) begin
            result_q  <= alu_result;
            rd_out_q  <= reg_dest_in;
            wen_out_q <= write_enable_in & (reg_dest_in != 5'd0);
          end else if (bad_op) begin
            err_q     <= 1'b1;
            wen_out_q <= 1'b0;
          end else begin
            state_q     <= ACCESS;
            req_q       <= 1'b1;
            we_q        <= is_store;
            addr_q      <= {alu_result[ADDR_WIDTH-1:2], 2'b00};
            wdata_q     <= is_store ? wdata_d : '0;
            wstrb_q     <= is_store ? wstrb_d : 4'b0000;
            wen_out_q   <= 1'b0;
            op_q        <= funct3;
            off_q       <= alu_result[1:0];
            rd_lat_q    <= reg_dest_in;
            wen_lat_q   <= write_enable_in;
            store_lat_q <= is_store;
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            wstrb_q  <= 4'b0000;
            rd_out_q <= rd_lat_q;
            if (store_lat_q) begin
              result_q  <= '0;
              wen_out_q <= 1'b0;
            end else begin
              result_q  <= load_d;
              wen_out_q <= wen_lat_q & (rd_lat_q != 5'd0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req         = req_q;
  assign dmem_we          = we_q;
  assign dmem_addr        = addr_q;
  assign dmem_wdata       = wdata_q;
  assign dmem_wstrb       = wstrb_q;
  assign data_result      = result_q;
  assign reg_dest_out     = rd_out_q;
  assign write_enable_out = wen_out_q;
  assign access_err       = err_q;

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - vector table plus scoreboard queue for the MEM stage
module tb_memory_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] alu_result, store_data;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [4:0]  reg_dest_in;
  logic        write_enable_in;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata, data_result;
  logic [4:0]  reg_dest_out;
  logic        write_enable_out, access_err;

  int total = 0;
  int bad   = 0;

  memory_access dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
    .store_data(store_data), .is_load(is_load), .is_store(is_store), .funct3(funct3),
    .reg_dest_in(reg_dest_in), .write_enable_in(write_enable_in), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata), .data_result(data_result), .reg_dest_out(reg_dest_out),
    .write_enable_out(write_enable_out), .access_err(access_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] sd;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] rdata;
    int          delay;
    logic        exp_req;
    logic        exp_err;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        chk_data;
    logic [31:0] exp_data;
    logic        exp_wen;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(logic valid, logic [31:0] alu, logic [31:0] sd, logic ld,
                              logic st, logic [2:0] f3, logic [4:0] rd, logic we,
                              logic [31:0] rdata, int delay, logic exp_req, logic exp_err,
                              logic [31:0] exp_addr, logic [31:0] exp_wdata,
                              logic [3:0] exp_wstrb, logic chk_data,
                              logic [31:0] exp_data, logic exp_wen);
    vec_t v;
    v.valid = valid; v.alu = alu; v.sd = sd; v.ld = ld; v.st = st; v.f3 = f3;
    v.rd = rd; v.we = we; v.rdata = rdata; v.delay = delay; v.exp_req = exp_req;
    v.exp_err = exp_err; v.exp_addr = exp_addr; v.exp_wdata = exp_wdata;
    v.exp_wstrb = exp_wstrb; v.chk_data = chk_data; v.exp_data = exp_data;
    v.exp_wen = exp_wen;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; alu_result = 0; store_data = 0; is_load = 0; is_store = 0;
    funct3 = 0; reg_dest_in = 0; write_enable_in = 0; dmem_ready = 0; dmem_rdata = 0;
  endtask

  task automatic do_op(input vec_t v);
    vec_t e;
    @(negedge clock);
    in_valid = v.valid; alu_result = v.alu; store_data = v.sd; is_load = v.ld;
    is_store = v.st; funct3 = v.f3; reg_dest_in = v.rd; write_enable_in = v.we;
    sb.push_back(v);
    #1;
    check("stall_present", stall, v.valid & (v.ld | v.st));
    @(posedge clock);
    @(negedge clock);
    if (v.exp_req) begin
      check("bubble_wen", write_enable_out, 0);
      for (int k = 0; k <= v.delay; k++) begin
        check("req_held", dmem_req, 1);
        check("we_held", dmem_we, v.st);
        check("addr_held", dmem_addr, v.exp_addr);
        if (v.st) begin
          check("wdata_held", dmem_wdata, v.exp_wdata);
          check("wstrb_held", dmem_wstrb, v.exp_wstrb);
        end
        dmem_ready = (k == v.delay);
        dmem_rdata = v.rdata;
        #1;
        check("stall_access", stall, k != v.delay);
        @(posedge clock);
        @(negedge clock);
      end
      dmem_ready = 0;
    end
    e = sb.pop_front();
    if (e.chk_data) check("data_result", data_result, e.exp_data);
    check("wen_out", write_enable_out, e.exp_wen);
    check("access_err", access_err, e.exp_err);
    check("req_low", dmem_req, 0);
    if (e.exp_wen) check("rd_out", reg_dest_out, e.rd);
    in_valid = 0;
    if (e.exp_err) begin
      @(posedge clock);
      @(negedge clock);
      check("err_pulse_end", access_err, 0);
      check("req_never", dmem_req, 0);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    #1;
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_wstrb", dmem_wstrb, 0);
    check("rst_wen", write_enable_out, 0);
    check("rst_err", access_err, 0);
    check("rst_data", data_result, 0);
    check("rst_stall", stall, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;

    //               valid alu           sd            ld st f3     rd  we rdata         dly req err addr          wdata         wstrb   chk data          wen
    vecs.push_back(mk(1, 32'h0000_1234, 32'h0,        0, 0, 3'b000, 5,  1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 1, 32'h0000_1234, 1));
    vecs.push_back(mk(1, 32'h0000_DEAD, 32'h0,        0, 0, 3'b000, 0,  1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 1, 32'h0000_DEAD, 0));
    vecs.push_back(mk(1, 32'h0000_0103, 32'h0,        1, 0, 3'b000, 7,  1, 32'h80FF_0000, 0, 1, 0, 32'h0000_0100, 32'h0,        4'b0000, 1, 32'hFFFF_FF80, 1));
    vecs.push_back(mk(1, 32'h0000_0202, 32'hABCD_1234, 0, 1, 3'b001, 0,  0, 32'h0,        3, 1, 0, 32'h0000_0200, 32'h1234_1234, 4'b1100, 1, 32'h0,        0));
    vecs.push_back(mk(1, 32'h0000_0101, 32'h0,        1, 0, 3'b010, 9,  1, 32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h0000_0002, 32'h0,        1, 0, 3'b101, 0,  1, 32'h8001_7FFF, 0, 1, 0, 32'h0000_0000, 32'h0,        4'b0000, 1, 32'h0000_8001, 0));
    vecs.push_back(mk(1, 32'h0000_0101, 32'h0,        1, 0, 3'b100, 3,  1, 32'h0000_9A00, 1, 1, 0, 32'h0000_0100, 32'h0,        4'b0000, 1, 32'h0000_009A, 1));
    vecs.push_back(mk(1, 32'h0000_0000, 32'h0,        1, 0, 3'b001, 4,  1, 32'h0000_8001, 0, 1, 0, 32'h0000_0000, 32'h0,        4'b0000, 1, 32'hFFFF_8001, 1));
    vecs.push_back(mk(1, 32'h0000_0201, 32'h0000_0055, 0, 1, 3'b000, 0,  0, 32'h0,        0, 1, 0, 32'h0000_0200, 32'h5555_5555, 4'b0010, 1, 32'h0,        0));
    vecs.push_back(mk(1, 32'h0000_0204, 32'hCAFE_F00D, 0, 1, 3'b010, 0,  0, 32'h0,        2, 1, 0, 32'h0000_0204, 32'hCAFE_F00D, 4'b1111, 1, 32'h0,        0));
    vecs.push_back(mk(1, 32'h0000_0300, 32'h0,        0, 1, 3'b100, 0,  0, 32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h0000_0300, 32'h0,        1, 0, 3'b011, 2,  1, 32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h0000_0008, 32'h0,        1, 0, 3'b010, 31, 1, 32'h1122_3344, 1, 1, 0, 32'h0000_0008, 32'h0,        4'b0000, 1, 32'h1122_3344, 1));
    vecs.push_back(mk(1, 32'h0000_0203, 32'h0000_7777, 0, 1, 3'b001, 0,  0, 32'h0,        0, 0, 1, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        0));
    vecs.push_back(mk(1, 32'h0000_0006, 32'h0,        1, 0, 3'b001, 6,  1, 32'h7ABC_0000, 0, 1, 0, 32'h0000_0004, 32'h0,        4'b0000, 1, 32'h0000_7ABC, 1));
    vecs.push_back(mk(0, 32'h0000_5555, 32'h0,        0, 0, 3'b000, 8,  1, 32'h0,        0, 0, 0, 32'h0,        32'h0,        4'b0000, 0, 32'h0,        0));

    for (int i = 0; i < vecs.size(); i++) do_op(vecs[i]);

    // Reset landing mid-access must drop the request and stall immediately.
    @(negedge clock);
    in_valid = 1; alu_result = 32'h0000_0300; is_load = 1; is_store = 0;
    funct3 = 3'b010; reg_dest_in = 5'd3; write_enable_in = 1;
    @(posedge clock);
    @(negedge clock);
    check("mid_req_up", dmem_req, 1);
    check("mid_stall_up", stall, 1);
    reset = 1;
    #1;
    check("mid_rst_req", dmem_req, 0);
    check("mid_rst_stall", stall, 0);
    check("mid_rst_addr", dmem_addr, 0);
    check("mid_rst_wen", write_enable_out, 0);
    check("mid_rst_data", data_result, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 0;
    idle_inputs();
    do_op(mk(1, 32'h0000_0042, 32'h0, 0, 0, 3'b000, 12, 1, 32'h0, 0, 0, 0, 32'h0,
             32'h0, 4'b0000, 1, 32'h0000_0042, 1));
    check("post_rst_req", dmem_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
